// File: rtl/sdram_read_responder.sv
// sdram_read_responder: turns a beat-indexed read request into Avalon-MM
// pipelined burst reads, one burst in flight, and streams the beats back.
module sdram_read_responder #(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 16,
    parameter int MAX_BURST = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       read_start,
    input  logic [ADDR_W-1:0]          read_addr,
    input  logic [CNT_W-1:0]           read_cnt,
    output logic [DATA_W-1:0]          read_data,
    output logic                       read_valid,
    output logic                       read_done,
    output logic                       busy,
    output logic [ADDR_W-1:0]          avm_address,
    output logic                       avm_read,
    output logic [$clog2(MAX_BURST):0] avm_burstcount,
    input  logic                       avm_waitrequest,
    input  logic [DATA_W-1:0]          avm_readdata,
    input  logic                       avm_readdatavalid
);

    localparam int BC_W  = $clog2(MAX_BURST) + 1;
    localparam int BYTES = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA,
        DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_idx;
    logic [CNT_W-1:0]    r_rem;
    logic [BC_W-1:0]     r_blen;
    logic [BC_W-1:0]     r_beats;
    logic [BC_W-1:0]     w_blen;
    logic                w_accept;
    logic                w_beat;
    logic                w_last_beat;

    // Burst length is the remaining count clipped to the largest burst.
    assign w_blen = (r_rem >= CNT_W'(MAX_BURST)) ? BC_W'(MAX_BURST)
                                                  : BC_W'(r_rem);
    assign w_accept    = (r_state == REQ) && !avm_waitrequest;
    assign w_beat      = (r_state == DATA) && avm_readdatavalid;
    assign w_last_beat = w_beat && (r_beats == (r_blen - BC_W'(1)));

    // State register; reset drops any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and Avalon/handshake outputs, all decoded from state.
    always_comb begin
        w_next         = r_state;
        avm_read       = 1'b0;
        avm_address    = '0;
        avm_burstcount = '0;
        read_done      = 1'b0;
        busy           = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (read_start) begin
                    w_next = (read_cnt == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                busy           = 1'b1;
                avm_read       = 1'b1;
                avm_address    = r_idx * ADDR_W'(BYTES);
                avm_burstcount = w_blen;
                if (!avm_waitrequest) begin
                    w_next = DATA;
                end
            end
            DATA: begin
                busy = 1'b1;
                if (w_last_beat) begin
                    w_next = (r_rem != '0) ? REQ : DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                read_done = 1'b1;
                w_next    = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Beat index, remaining count, per-burst beat counter and read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_rem      <= '0;
            r_blen     <= '0;
            r_beats    <= '0;
            read_valid <= 1'b0;
            read_data  <= '0;
        end else begin
            if ((r_state == IDLE) && read_start) begin
                r_idx <= read_addr;
                r_rem <= read_cnt;
            end
            if (w_accept) begin
                r_rem   <= r_rem - CNT_W'(w_blen);
                r_idx   <= r_idx + ADDR_W'(w_blen);
                r_blen  <= w_blen;
                r_beats <= '0;
            end
            if (w_beat) begin
                r_beats   <= r_beats + BC_W'(1);
                read_data <= avm_readdata;
            end
            read_valid <= w_beat;
        end
    end

endmodule

// File: tb/tb_sdram_read_responder.sv
// tb_sdram_read_responder: scoreboard bench with a behavioural Avalon slave
// returning address-derived data one cycle after each accepted burst.
module tb_sdram_read_responder;

    logic         clk;
    logic         rst;
    logic         read_start;
    logic [31:0]  read_addr;
    logic [15:0]  read_cnt;
    logic [127:0] read_data;
    logic         read_valid;
    logic         read_done;
    logic         busy;
    logic [31:0]  avm_address;
    logic         avm_read;
    logic [4:0]   avm_burstcount;
    logic         avm_waitrequest;
    logic [127:0] avm_readdata;
    logic         avm_readdatavalid;

    sdram_read_responder dut (
        .clk               (clk),
        .rst               (rst),
        .read_start        (read_start),
        .read_addr         (read_addr),
        .read_cnt          (read_cnt),
        .read_data         (read_data),
        .read_valid        (read_valid),
        .read_done         (read_done),
        .busy              (busy),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_burstcount    (avm_burstcount),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bit [127:0] data_q[$];
    bit [31:0]  baddr_q[$];
    int         bc_q[$];
    bit         last_q[$];

    int nvalid = 0;
    int ndone  = 0;
    int nacc   = 0;
    int nstall = 0;

    int         pend      = 0;
    bit [31:0]  sbyte     = 0;
    int         wr_hold   = 0;
    bit         stray_req = 0;
    bit         stall_on  = 0;
    bit [31:0]  st_addr   = 0;
    int         st_bc     = 0;
    bit         acc       = 0;
    int         acc_bc    = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit [127:0] mem(input bit [31:0] b);
        return {b ^ 32'hA5A5A5A5, ~b, b + 32'h1234, b};
    endfunction

    // Expected beats, bursts and done flavour for one request.
    task automatic push_exp(input bit [31:0] a, input int c);
        bit [31:0] idx;
        int        rem;
        int        bl;
        for (int i = 0; i < c; i++) begin
            idx = a + 32'(i);
            data_q.push_back(mem(idx * 32'd16));
        end
        idx = a;
        rem = c;
        while (rem > 0) begin
            bl = (rem > 16) ? 16 : rem;
            baddr_q.push_back(idx * 32'd16);
            bc_q.push_back(bl);
            idx = idx + 32'(bl);
            rem = rem - bl;
        end
        last_q.push_back(c != 0);
    endtask

    task automatic start(input bit [31:0] a, input int c);
        push_exp(a, c);
        @(posedge clk);
        #1;
        read_start = 1'b1;
        read_addr  = a;
        read_cnt   = 16'(c);
        @(posedge clk);
        #1;
        read_start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int maxc);
        for (int i = 0; i < maxc && ndone < target; i++) begin
            @(negedge clk);
            #1;
        end
        if (ndone < target) chk("timeout_done", 128'(ndone), 128'(target));
    endtask

    task automatic wait_valid(input int target, input int maxc);
        for (int i = 0; i < maxc && nvalid < target; i++) begin
            @(negedge clk);
            #1;
        end
        if (nvalid < target) chk("timeout_valid", 128'(nvalid), 128'(target));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rvalid"}, 128'(read_valid), 128'(0));
        chk({tag, "_rdone"}, 128'(read_done), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_avmrd"}, 128'(avm_read), 128'(0));
        chk({tag, "_addr"}, 128'(avm_address), 128'(0));
        chk({tag, "_bc"}, 128'(avm_burstcount), 128'(0));
        chk({tag, "_rdata"}, read_data, 128'(0));
    endtask

    // Avalon slave: checks each accepted burst, returns its beats.
    initial begin
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        forever begin
            @(negedge clk);
            acc = avm_read && !avm_waitrequest;
            if (avm_read && avm_waitrequest) begin
                if (!stall_on) begin
                    stall_on = 1'b1;
                    st_addr  = avm_address;
                    st_bc    = int'(avm_burstcount);
                end else begin
                    chk("stall_addr", 128'(avm_address), 128'(st_addr));
                    chk("stall_bc", 128'(avm_burstcount), 128'(st_bc));
                end
                nstall++;
            end
            if (acc) begin
                stall_on = 1'b0;
                nacc++;
                chk("one_outstanding", 128'(pend), 128'(0));
                if (baddr_q.size() == 0) begin
                    chk("unexp_burst", 128'(1), 128'(0));
                end else begin
                    chk("burst_addr", 128'(avm_address), 128'(baddr_q.pop_front()));
                    chk("burst_len", 128'(avm_burstcount), 128'(bc_q.pop_front()));
                end
                sbyte  = avm_address;
                acc_bc = int'(avm_burstcount);
            end
            @(posedge clk);
            #1;
            if (acc) pend = acc_bc;
            if (pend > 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = mem(sbyte);
                sbyte             = sbyte + 32'd16;
                pend--;
            end else if (stray_req) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = '1;
                stray_req         = 1'b0;
            end else begin
                avm_readdatavalid = 1'b0;
                avm_readdata      = '0;
            end
            avm_waitrequest = avm_read && (wr_hold > 0);
            if (avm_waitrequest) wr_hold--;
        end
    end

    // Output monitor: pops the scoreboard on every returned beat.
    initial begin
        forever begin
            @(negedge clk);
            if (read_valid) begin
                nvalid++;
                if (data_q.size() == 0) chk("unexp_valid", 128'(1), 128'(0));
                else chk("rdata", read_data, data_q.pop_front());
            end
            if (read_done) begin
                ndone++;
                if (last_q.size() == 0) chk("unexp_done", 128'(1), 128'(0));
                else chk("done_with_last", 128'(read_valid), 128'(last_q.pop_front()));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int v0;
        int a0;
        int s0;
        int d0;
        rst        = 1'b1;
        read_start = 1'b0;
        read_addr  = '0;
        read_cnt   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single short burst
        v0 = nvalid; a0 = nacc;
        start(32'h10, 4);
        wait_done(1, 100);
        chk("t1_valid", 128'(nvalid - v0), 128'(4));
        chk("t1_acc", 128'(nacc - a0), 128'(1));
        chk("t1_q", 128'(data_q.size()), 128'(0));

        // back-to-back, split into 16/16/8
        v0 = nvalid; a0 = nacc;
        start(32'h20, 40);
        wait_done(2, 400);
        chk("t2_valid", 128'(nvalid - v0), 128'(40));
        chk("t2_acc", 128'(nacc - a0), 128'(3));
        chk("t2_bq", 128'(baddr_q.size()), 128'(0));

        // waitrequest held five cycles
        v0 = nvalid; a0 = nacc; s0 = nstall;
        wr_hold = 5;
        start(32'h7, 3);
        wait_done(3, 100);
        chk("t3_stall", 128'(nstall - s0), 128'(5));
        chk("t3_acc", 128'(nacc - a0), 128'(1));
        chk("t3_valid", 128'(nvalid - v0), 128'(3));

        // zero-length request
        a0 = nacc;
        push_exp(32'h5, 0);
        @(posedge clk);
        #1;
        read_start = 1'b1;
        read_addr  = 32'h5;
        read_cnt   = 16'd0;
        @(posedge clk);
        #1;
        read_start = 1'b0;
        chk("t4_busy1", 128'(busy), 128'(1));
        chk("t4_done1", 128'(read_done), 128'(1));
        chk("t4_avmrd", 128'(avm_read), 128'(0));
        @(posedge clk);
        #1;
        chk("t4_busy0", 128'(busy), 128'(0));
        chk("t4_done0", 128'(read_done), 128'(0));
        wait_done(4, 20);
        chk("t4_acc", 128'(nacc - a0), 128'(0));

        // stray readdatavalid in IDLE, read_start during DATA
        v0 = nvalid; a0 = nacc;
        stray_req = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t5_stray", 128'(nvalid - v0), 128'(0));
        start(32'h100, 8);
        wait_valid(v0 + 2, 50);
        @(posedge clk);
        #1;
        read_start = 1'b1;
        read_addr  = 32'h999;
        read_cnt   = 16'd5;
        @(posedge clk);
        #1;
        read_start = 1'b0;
        wait_done(5, 100);
        repeat (10) @(posedge clk);
        #1;
        chk("t5_valid", 128'(nvalid - v0), 128'(8));
        chk("t5_acc", 128'(nacc - a0), 128'(1));
        chk("t5_done", 128'(ndone), 128'(5));

        // beat index wraps past the top of the address space
        v0 = nvalid; a0 = nacc;
        start(32'h0FFFFFFE, 20);
        wait_done(6, 200);
        chk("t6_valid", 128'(nvalid - v0), 128'(20));
        chk("t6_acc", 128'(nacc - a0), 128'(2));

        // reset after two of eight beats
        v0 = nvalid; d0 = ndone;
        start(32'h40, 8);
        wait_valid(v0 + 2, 50);
        rst = 1'b1;
        #1;
        chk_zero("t7_rst");
        data_q.delete();
        baddr_q.delete();
        bc_q.delete();
        last_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        v0 = nvalid;
        repeat (10) @(posedge clk);
        #1;
        chk("t7_ignored", 128'(nvalid - v0), 128'(0));
        chk("t7_nodone", 128'(ndone - d0), 128'(0));
        start(32'h55, 2);
        wait_done(d0 + 1, 100);
        chk("t7_valid", 128'(nvalid - v0), 128'(2));
        chk("t7_q", 128'(data_q.size()), 128'(0));

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_read_responder.md
SDRAM_READ_RESPONDER -- requirements
Module: sdram_read_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 128, read data width in bits (beat size = DATA_W/8 bytes).
REQ-002 SHALL have parameter ADDR_W, default 32, Avalon byte-address width.
REQ-003 SHALL have parameter CNT_W, default 16, width of read_cnt.
REQ-004 SHALL have parameter MAX_BURST, default 16, maximum Avalon burst length in beats, power of two.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port read_start  input  1  one-cycle request pulse from the fetch initiator.
REQ-008 SHALL have port read_addr  input  ADDR_W  start beat index, sampled with read_start.
REQ-009 SHALL have port read_cnt  input  CNT_W  number of beats, sampled with read_start.
REQ-010 SHALL have port read_data  output  DATA_W  returned beat.
REQ-011 SHALL have port read_valid  output  1  read_data qualifier.
REQ-012 SHALL have port read_done  output  1  one-cycle pulse, transfer complete.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have ports avm_address (output, ADDR_W), avm_read (output, 1), avm_burstcount (output, $clog2(MAX_BURST)+1), avm_waitrequest (input, 1), avm_readdata (input, DATA_W), avm_readdatavalid (input, 1): Avalon-MM pipelined burst read master.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, DATA, DONE.
REQ-016 SHALL, in IDLE on read_start=1, latch the address, remaining = read_cnt; go to DONE if read_cnt==0, else REQ.
REQ-017 SHALL ignore read_start in any state other than IDLE.
REQ-018 SHALL, in REQ, drive avm_read=1, avm_address = current beat index * (DATA_W/8) truncated to ADDR_W, avm_burstcount = min(remaining, MAX_BURST).
REQ-019 SHALL hold avm_read, avm_address, avm_burstcount stable while avm_waitrequest=1.
REQ-020 SHALL, on cycle with avm_read=1 and avm_waitrequest=0, deassert avm_read next cycle, subtract burst length from remaining, advance beat index by burst length, go to DATA.
REQ-021 SHALL keep at most one burst outstanding; next burst issued only after all beats of current burst return.
REQ-022 SHALL, in DATA, count avm_readdatavalid beats; on the last beat of the burst go to REQ if remaining>0, else DONE.
REQ-023 SHALL register read_data <= avm_readdata and read_valid <= avm_readdatavalid qualified by state DATA: exactly one-cycle latency.
REQ-024 SHALL ignore avm_readdatavalid outside DATA (read_valid stays 0).
REQ-025 SHALL assert read_done for exactly one cycle while in DONE, then go to IDLE; for nonzero count read_done coincides with final read_valid.
REQ-026 SHALL produce exactly read_cnt read_valid pulses per transfer, in address order.
REQ-027 SHALL wrap the beat index modulo 2^ADDR_W without error.
REQ-028 SHALL accept a new read_start in the cycle directly after read_done (back-to-back).

Reset
REQ-029 SHALL, on rst=1, immediately enter IDLE and clear avm_read, avm_burstcount, avm_address, read_valid, read_done, busy, read_data to 0, asynchronously.
REQ-030 SHALL, on reset mid-transfer, abandon the transfer; beats arriving after reset release SHALL be ignored.

Verification
REQ-031 SHALL pass: start addr=0x10, cnt=4, waitrequest=0, data 1 cycle after accept -> one burst addr=0x100, burstcount=4, four read_valid with data in order, read_done with 4th.
REQ-032 SHALL pass: cnt=40, MAX_BURST=16 -> bursts 16,16,8 at byte addrs base, base+256, base+512; 40 read_valid, one read_done.
REQ-033 SHALL pass: waitrequest held 5 cycles -> avm_read/address/burstcount unchanged all 5 cycles; single accept.
REQ-034 SHALL pass: cnt=0 -> no avm_read; read_done 1 cycle after start; busy high one cycle.
REQ-035 SHALL pass: read_start during DATA, and stray readdatavalid in IDLE -> both ignored, counts unaffected.
REQ-036 SHALL pass: rst asserted after 2 of 8 beats -> all outputs 0 same cycle; new cnt=2 transfer afterward completes with exactly 2 read_valid.
